// File: rtl/load_store_unit.sv
// Memory-access stage: sizes loads/stores onto a word-wide handshaked port,
// extends load data and stalls the datapath while an access is in flight.
module load_store_unit #(
   parameter int TIMEOUT = 16,
   parameter int XLEN    = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   input  logic            req_we,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] rdata,
   output logic            stall,
   output logic            misaligned,
   output logic            illegal,
   output logic            bus_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_wstrb,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ready,
   input  logic [XLEN-1:0] mem_rdata
);

   // state | meaning
   // IDLE  | waiting for a legal, aligned request
   // BUSY  | mem_req held; waiting for mem_ready or timeout
   // DONE  | rdata / bus_err valid for this single cycle
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]      state;
   logic [7:0]      wait_cnt;
   logic [2:0]      f3_q;
   logic [1:0]      off_q;

   logic            f3_legal;
   logic            aligned;
   logic            in_idle;
   logic            accept;
   logic [3:0]      wstrb_nxt;
   logic [XLEN-1:0] wdata_nxt;
   logic [7:0]      byte_lane;
   logic [15:0]     half_lane;
   logic [XLEN-1:0] load_ext;

   always_comb begin
      f3_legal = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = ~req_we;
         default:                f3_legal = 1'b0;
      endcase
   end

   always_comb begin
      aligned = 1'b0;
      case (funct3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~addr[0];
         2'b10:   aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   assign in_idle    = (state == ST_IDLE);
   assign illegal    = in_idle & req_valid & ~f3_legal;
   assign misaligned = in_idle & req_valid & f3_legal & ~aligned;
   assign accept     = in_idle & req_valid & f3_legal & aligned;
   assign stall      = accept | (state == ST_BUSY);

   // Store lanes are replicated so the memory only has to honour the strobes.
   always_comb begin
      wstrb_nxt = 4'b0000;
      wdata_nxt = '0;
      if (req_we) begin
         case (funct3[1:0])
            2'b00: begin
               wstrb_nxt = 4'b0001 << addr[1:0];
               wdata_nxt = {4{wdata[7:0]}};
            end
            2'b01: begin
               wstrb_nxt = addr[1] ? 4'b1100 : 4'b0011;
               wdata_nxt = {2{wdata[15:0]}};
            end
            default: begin
               wstrb_nxt = 4'b1111;
               wdata_nxt = wdata;
            end
         endcase
      end
   end

   always_comb begin
      byte_lane = mem_rdata[7:0];
      case (off_q)
         2'b00:   byte_lane = mem_rdata[7:0];
         2'b01:   byte_lane = mem_rdata[15:8];
         2'b10:   byte_lane = mem_rdata[23:16];
         default: byte_lane = mem_rdata[31:24];
      endcase
      half_lane = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_ext  = mem_rdata;
      case (f3_q)
         3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
         3'b100:  load_ext = {24'd0, byte_lane};
         3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
         3'b101:  load_ext = {16'd0, half_lane};
         default: load_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         f3_q      <= '0;
         off_q     <= '0;
         rdata     <= '0;
         bus_err   <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wstrb <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               rdata   <= '0;
               bus_err <= 1'b0;
               if (accept) begin
                  state     <= ST_BUSY;
                  mem_req   <= 1'b1;
                  mem_we    <= req_we;
                  mem_addr  <= {addr[XLEN-1:2], 2'b00};
                  mem_wstrb <= wstrb_nxt;
                  mem_wdata <= wdata_nxt;
                  f3_q      <= funct3;
                  off_q     <= addr[1:0];
                  wait_cnt  <= 8'(TIMEOUT - 1);
               end
            end
            ST_BUSY: begin
               // A ready arriving on the timeout cycle still counts as completion.
               if (mem_ready) begin
                  state     <= ST_DONE;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_wstrb <= '0;
                  rdata     <= mem_we ? '0 : load_ext;
                  bus_err   <= 1'b0;
               end else if (wait_cnt == 8'd0) begin
                  state     <= ST_DONE;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_wstrb <= '0;
                  rdata     <= '0;
                  bus_err   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 8'd1;
               end
            end
            ST_DONE: begin
               state   <= ST_IDLE;
               rdata   <= '0;
               bus_err <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT=4.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        stall, misaligned, illegal, bus_err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int vectors = 0;
   int miscompares = 0;

   load_store_unit #(.TIMEOUT(4), .XLEN(32)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
      .stall(stall), .misaligned(misaligned), .illegal(illegal),
      .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Present a request at a negedge; leaves the caller just before the next posedge.
   task automatic drive_req(input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
      mem_ready = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0; req_valid = 0; req_we = 0; funct3 = 0; addr = 0; wdata = 0;
      mem_ready = 0; mem_rdata = 0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({rdata, bus_err, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== '0) begin
         miscompares++; $display("FAIL reset_regs: got mem_req=%b mem_addr=%h rdata=%h, want all 0", mem_req, mem_addr, rdata);
      end
      reset = 1'b1;
      drive_req(1'b0, 3'b010, 32'h0000_0104, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      vectors++;
      if (mem_req !== 1'b1) begin
         miscompares++; $display("FAIL reset_busy_req: got %b want 1", mem_req);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      vectors++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0 || stall !== 1'b0) begin
         miscompares++; $display("FAIL reset_midbusy: got mem_req=%b mem_addr=%h stall=%b want 0/0/0", mem_req, mem_addr, stall);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (stall !== 1'b0 || mem_req !== 1'b0) begin
         miscompares++; $display("FAIL reset_release: got stall=%b mem_req=%b want 0/0", stall, mem_req);
      end
   endtask

   // Runs a load with ready one cycle after acceptance; returns rdata seen in DONE.
   task automatic run_load(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, output logic [31:0] got,
                           output int stall_cycles);
      stall_cycles = 0;
      drive_req(1'b0, f3, a, 32'h0);
      if (stall) stall_cycles++;
      @(posedge clk); #1;
      @(negedge clk);
      req_valid = 1'b0; mem_ready = 1'b1; mem_rdata = rd;
      #1;
      if (stall) stall_cycles++;
      @(posedge clk); #1;
      if (stall) stall_cycles++;
      got = rdata;
      @(negedge clk);
      mem_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_load_word;
      logic [31:0] got;
      int sc;
      drive_req(1'b0, 3'b010, 32'h0000_0104, 32'h0);
      @(posedge clk); #1;
      vectors++;
      if (mem_addr !== 32'h0000_0104 || mem_wstrb !== 4'b0000 || mem_we !== 1'b0 || mem_req !== 1'b1) begin
         miscompares++; $display("FAIL lw_port: got addr=%h wstrb=%b we=%b req=%b want 104/0000/0/1", mem_addr, mem_wstrb, mem_we, mem_req);
      end
      @(negedge clk);
      req_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      vectors++;
      if (rdata !== 32'hDEAD_BEEF || bus_err !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin
         miscompares++; $display("FAIL lw_done: got rdata=%h err=%b stall=%b req=%b want deadbeef/0/0/0", rdata, bus_err, stall, mem_req);
      end
      @(negedge clk); mem_ready = 1'b0;
      @(posedge clk); #1;
      run_load(3'b010, 32'h0000_0104, 32'hDEAD_BEEF, got, sc);
      vectors++;
      if (sc != 2) begin
         miscompares++; $display("FAIL lw_stall_cycles: got %0d want 2", sc);
      end
   endtask

   task automatic test_load_sub;
      logic [31:0] got;
      int sc;
      run_load(3'b000, 32'h0000_0203, 32'h80FF_1234, got, sc);
      vectors++;
      if (got !== 32'hFFFF_FF80) begin
         miscompares++; $display("FAIL lb: got %h want ffffff80", got);
      end
      run_load(3'b100, 32'h0000_0203, 32'h80FF_1234, got, sc);
      vectors++;
      if (got !== 32'h0000_0080) begin
         miscompares++; $display("FAIL lbu: got %h want 00000080", got);
      end
      run_load(3'b001, 32'h0000_0202, 32'h80FF_1234, got, sc);
      vectors++;
      if (got !== 32'hFFFF_80FF) begin
         miscompares++; $display("FAIL lh: got %h want ffff80ff", got);
      end
      run_load(3'b101, 32'h0000_0200, 32'h80FF_9234, got, sc);
      vectors++;
      if (got !== 32'h0000_9234) begin
         miscompares++; $display("FAIL lhu: got %h want 00009234", got);
      end
      run_load(3'b000, 32'h0000_0201, 32'h80FF_1234, got, sc);
      vectors++;
      if (got !== 32'h0000_0012) begin
         miscompares++; $display("FAIL lb_pos: got %h want 00000012", got);
      end
   endtask

   task automatic test_store;
      logic [2:0]  f3s [3] = '{3'b001, 3'b000, 3'b010};
      logic [31:0] adr [3] = '{32'h302, 32'h301, 32'h300};
      logic [31:0] wds [3] = '{32'h0000_ABCD, 32'h0000_0055, 32'h1234_5678};
      logic [3:0]  exs [3] = '{4'b1100, 4'b0010, 4'b1111};
      logic [31:0] exd [3] = '{32'hABCD_ABCD, 32'h5555_5555, 32'h1234_5678};
      for (int i = 0; i < 3; i++) begin
         drive_req(1'b1, f3s[i], adr[i], wds[i]);
         @(posedge clk); #1;
         vectors++;
         if (mem_we !== 1'b1 || mem_wstrb !== exs[i] || mem_wdata !== exd[i] || mem_addr !== 32'h300) begin
            miscompares++; $display("FAIL store_%0d: got we=%b strb=%b data=%h addr=%h want 1/%b/%h/300", i, mem_we, mem_wstrb, mem_wdata, mem_addr, exs[i], exd[i]);
         end
         @(negedge clk);
         req_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
         @(posedge clk); #1;
         vectors++;
         if (rdata !== 32'h0 || bus_err !== 1'b0) begin
            miscompares++; $display("FAIL store_done_%0d: got rdata=%h err=%b want 0/0", i, rdata, bus_err);
         end
         @(negedge clk); mem_ready = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reject;
      logic        we_v [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [2:0]  f3_v [4] = '{3'b010, 3'b011, 3'b001, 3'b100};
      logic [31:0] a_v  [4] = '{32'h102, 32'h100, 32'h103, 32'h100};
      logic        mis_v[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic        ill_v[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive_req(we_v[i], f3_v[i], a_v[i], 32'h0);
         vectors++;
         if (misaligned !== mis_v[i] || illegal !== ill_v[i] || stall !== 1'b0) begin
            miscompares++; $display("FAIL reject_%0d: got mis=%b ill=%b stall=%b want %b/%b/0", i, misaligned, illegal, stall, mis_v[i], ill_v[i]);
         end
         @(posedge clk); #1;
         vectors++;
         if (mem_req !== 1'b0) begin
            miscompares++; $display("FAIL reject_req_%0d: got %b want 0", i, mem_req);
         end
      end
      @(negedge clk); req_valid = 1'b0;
   endtask

   task automatic test_timeout;
      int n = 0;
      drive_req(1'b0, 3'b010, 32'h0000_0400, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      while (mem_req === 1'b1 && n < 20) begin
         n++;
         @(posedge clk); #1;
      end
      vectors++;
      if (n != 4 || bus_err !== 1'b1 || rdata !== 32'h0) begin
         miscompares++; $display("FAIL timeout: got busy=%0d err=%b rdata=%h want 4/1/0", n, bus_err, rdata);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus_err !== 1'b0) begin
         miscompares++; $display("FAIL timeout_clear: got err=%b want 0", bus_err);
      end
      drive_req(1'b0, 3'b010, 32'h0000_0400, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
      #1;
      vectors++;
      if (mem_req !== 1'b1 || stall !== 1'b1) begin
         miscompares++; $display("FAIL timeout_busy4: got req=%b stall=%b want 1/1", mem_req, stall);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus_err !== 1'b0 || rdata !== 32'hCAFE_F00D || mem_req !== 1'b0) begin
         miscompares++; $display("FAIL timeout_ready: got err=%b rdata=%h req=%b want 0/cafef00d/0", bus_err, rdata, mem_req);
      end
      @(negedge clk); mem_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      drive_req(1'b0, 3'b010, 32'h0000_0500, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
      @(posedge clk); #1;
      // DONE with req_valid still high: must be ignored
      vectors++;
      if (stall !== 1'b0 || misaligned !== 1'b0 || illegal !== 1'b0) begin
         miscompares++; $display("FAIL b2b_done: got stall=%b mis=%b ill=%b want 0/0/0", stall, misaligned, illegal);
      end
      @(posedge clk); #1;
      vectors++;
      if (mem_req !== 1'b0 || stall !== 1'b1) begin
         miscompares++; $display("FAIL b2b_idle: got req=%b stall=%b want 0/1", mem_req, stall);
      end
      @(negedge clk); mem_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
         miscompares++; $display("FAIL b2b_second: got req=%b addr=%h want 1/500", mem_req, mem_addr);
      end
      @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h3333_4444;
      @(posedge clk); #1;
      vectors++;
      if (rdata !== 32'h3333_4444) begin
         miscompares++; $display("FAIL b2b_rdata: got %h want 33334444", rdata);
      end
      @(negedge clk); mem_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_load_sub();
      test_store();
      test_reject();
      test_timeout();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the core datapath. Consumes the ALU result as the address and the rs2 value as store data, and drives a word-wide handshaked data-memory port.
- Returns sign- or zero-extended load data to the datapath's result mux.
- Asserts a stall while an access is in flight so that the PC and register file hold.
- Sizes byte, half and word accesses with write strobes and flags misaligned or illegal requests.

Parameters:
- TIMEOUT, 16, number of BUSY cycles without mem_ready before the access is aborted with bus_err; legal range 1..255.
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  datapath requests a memory access this cycle.
- req_we  input  1  1 = store, 0 = load.
- funct3  input  3  access size/sign, using RISC-V encoding.
- addr  input  32  byte address (ALU output).
- wdata  input  32  store data (rs2).
- rdata  output  32  extended load data; valid in DONE.
- stall  output  1  datapath must hold PC and must not write the register file.
- misaligned  output  1  combinational; request rejected because of alignment.
- illegal  output  1  combinational; request rejected because funct3 is illegal.
- bus_err  output  1  registered; DONE reached by timeout.
- mem_req  output  1  memory request strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wstrb  output  4  byte write enables.
- mem_wdata  output  32  lane-replicated store data.
- mem_ready  input  1  memory completes the access this cycle.
- mem_rdata  input  32  read word; valid when mem_ready=1.

Behaviour:
- Reset is asynchronous, active-low. While reset=0:
  - state = IDLE.
  - All registered outputs are 0: rdata, bus_err, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata.
  - A reset asserted mid-access drops mem_req immediately and the access is abandoned.
- funct3 decode:
  - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
  - BU and HU are legal only when req_we=0.
  - All other codes are illegal.
- Alignment rules:
  - H/HU need addr[0]=0.
  - W needs addr[1:0]=00.
  - B/BU are always aligned.
- State machine states: IDLE, BUSY, DONE.
- IDLE:
  - A request is accepted when req_valid=1, it is legal and it is aligned.
  - On acceptance, the next state is BUSY. On the same edge the unit registers mem_req=1, mem_we, mem_addr, mem_wstrb and mem_wdata, and latches funct3 and addr[1:0].
  - A rejected request gives: misaligned or illegal =1 for that cycle, stall=0, no memory activity, state stays IDLE.
- BUSY:
  - mem_req is held at 1 and all mem_* outputs are held stable.
  - The wait counter increments every cycle.
  - mem_ready=1 takes the unit to DONE. On that edge mem_req returns to 0, rdata is captured from the extended mem_rdata (for loads; 0 for stores) and bus_err=0.
  - If the counter reaches TIMEOUT with no mem_ready, the unit goes to DONE with rdata=0, bus_err=1 and mem_req=0.
  - mem_ready in the same cycle as the timeout has priority: the access is a normal completion.
- DONE:
  - stall=0 and rdata/bus_err are valid for exactly this cycle.
  - The next state is always IDLE.
  - A req_valid seen in DONE is ignored; the datapath presents the next instruction's request in IDLE.
- stall = (state==IDLE & accepted request) | (state==BUSY). It is combinational.
- Minimum accepted-access latency is 3 cycles (IDLE, BUSY with ready, DONE); stall is high for the first 2.
- Store lanes, with o = addr[1:0]:
  - B: mem_wdata = {4{wdata[7:0]}}, mem_wstrb = 4'b0001<<o.
  - H: mem_wdata = {2{wdata[15:0]}}, mem_wstrb = 0011 if o=00, 1100 if o=10.
  - W: mem_wdata = wdata, mem_wstrb = 1111.
- Loads: mem_we=0 and mem_wstrb=0000.
  - Byte lane is mem_rdata[8*o+7:8*o]; halfword lane is mem_rdata[16*o[1]+15:16*o[1]].
  - B and H sign-extend from the lane MSB; BU and HU zero-extend; W passes mem_rdata through.
- mem_ready is ignored in IDLE and DONE.
- misaligned and illegal are 0 outside IDLE.

Test Plan:
- Reset: hold reset=0 mid-BUSY -> mem_req falls to 0 immediately, all registered outputs 0; after release, state IDLE and stall=0.
- LW, addr=0x104, mem_ready one cycle later, mem_rdata=0xDEADBEEF -> mem_addr=0x104, mem_wstrb=0000, stall high 2 cycles, rdata=0xDEADBEEF in DONE.
- LB and LBU at addr=0x203 with mem_rdata=0x80FF1234 -> LB gives rdata=0xFFFFFF80, LBU gives rdata=0x00000080.
- SH at addr=0x302, wdata=0x0000ABCD -> mem_we=1, mem_wstrb=1100, mem_wdata=0xABCDABCD; SB at addr=0x301, wdata=0x55 -> mem_wstrb=0010, mem_wdata=0x55555555.
- LW at addr=0x102 -> misaligned=1, stall=0, mem_req never asserted. funct3=011 -> illegal=1. SH at addr=0x103 -> misaligned=1.
- TIMEOUT=4, mem_ready held 0 -> DONE after 4 BUSY cycles with bus_err=1 and rdata=0. Repeat with mem_ready=1 in the 4th BUSY cycle -> bus_err=0 and rdata=mem_rdata.
